// File: rtl/dwt53_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dwt53_pkg
// Description : Shared definitions for the 5/3 lifting datapath: flag bit
//               positions, lifting mode encodings and the narrowing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dwt53_pkg;

    // Bit positions inside the 3-bit flags word
    localparam int FLG_EN   = 2;
    localparam int FLG_INV  = 1;
    localparam int FLG_PRED = 0;

    // Lifting mode, encoded as {inverse, predict}
    typedef enum logic [1:0] {
        FWD_UPD  = 2'b00,
        FWD_PRED = 2'b01,
        INV_UPD  = 2'b10,
        INV_PRED = 2'b11
    } lift_mode_e;

    // Narrowed value (sign-extended to 32 bits) plus clamp/wrap indicator
    typedef struct packed {
        logic signed [31:0] value;
        logic               flag;
    } narrow_t;

    // Narrow a signed value to ow bits, either clamping (sat=1) or keeping
    // the ow LSBs (sat=0). flag reports that the value could not be kept.
    // ow is expected to be an elaboration-time constant in 2..31.
    function automatic narrow_t sat_narrow(input logic signed [31:0] value,
                                           input int                 ow,
                                           input bit                 sat);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] wrapped;
        narrow_t            r;
        hi      = (32'sd1 <<< (ow - 1)) - 32'sd1;
        lo      = -hi - 32'sd1;
        wrapped = (value <<< (32 - ow)) >>> (32 - ow);
        r.value = value;
        r.flag  = 1'b0;
        if (sat) begin
            if (value > hi) begin
                r.value = hi;
                r.flag  = 1'b1;
            end else if (value < lo) begin
                r.value = lo;
                r.flag  = 1'b1;
            end
        end else begin
            r.value = wrapped;
            r.flag  = (wrapped != value);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lift_step_core.sv
`default_nettype none
// ============================================================================
// Module      : lift_step_core
// Description : Combinational second-stage math of the 5/3 lifting step:
//               shift of the pre-summed neighbours, add/sub against the
//               centre sample and narrowing to the output width.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_step_core
    import dwt53_pkg::*;
#(
    parameter int IW  = 10,
    parameter int OW  = 11,
    parameter int SAT = 1
) (
    input  logic        [2:0]    i_flags,
    input  logic signed [IW-1:0] i_sam,
    input  logic signed [IW+1:0] i_sum,   // left+right, +2 already added for update
    output logic signed [OW-1:0] o_res,
    output logic                 o_sat
);

    lift_mode_e             w_mode;
    logic signed [IW+1:0]   w_sam_x;
    logic signed [IW+1:0]   w_pred;
    logic signed [IW+1:0]   w_upd;
    logic signed [IW+1:0]   w_full;

    assign w_mode  = lift_mode_e'(i_flags[FLG_INV:FLG_PRED]);
    assign w_sam_x = (IW+2)'(i_sam);
    assign w_pred  = i_sum >>> 1;
    assign w_upd   = i_sum >>> 2;

    // Full-precision lifting result; disabled steps pass the sample through
    always_comb begin
        w_full = w_sam_x;
        if (i_flags[FLG_EN]) begin
            case (w_mode)
                FWD_PRED: w_full = w_sam_x - w_pred;
                FWD_UPD:  w_full = w_sam_x + w_upd;
                INV_PRED: w_full = w_sam_x + w_pred;
                INV_UPD:  w_full = w_sam_x - w_upd;
                default:  w_full = w_sam_x;
            endcase
        end
    end

    generate
        if (OW >= IW + 2) begin : g_wide
            // Every full-precision value fits, so nothing can clamp or wrap
            assign o_res = OW'(w_full);
            assign o_sat = 1'b0;
        end else begin : g_narrow
            narrow_t w_n;
            assign w_n   = sat_narrow(32'(w_full), OW, SAT != 0);
            assign o_res = OW'(w_n.value);
            assign o_sat = w_n.flag;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lift_step_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lift_step_pipe
// Description : Two-stage pipelined 5/3 lifting step (forward/inverse,
//               predict/update) with valid/ready flow control, sideband tag
//               and optional output saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_step_pipe
    import dwt53_pkg::*;
#(
    parameter int IW  = 10,
    parameter int OW  = 11,
    parameter int TW  = 4,
    parameter int SAT = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic        [2:0]    flags_i,
    input  logic signed [IW-1:0] left_i,
    input  logic signed [IW-1:0] sam_i,
    input  logic signed [IW-1:0] right_i,
    input  logic        [TW-1:0] tag_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic signed [OW-1:0] res_o,
    output logic        [TW-1:0] tag_o,
    output logic                 sat_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    // Stage 1 registers
    logic signed [IW-1:0] r_s1_sam;
    logic signed [IW+1:0] r_s1_sum;
    logic        [2:0]    r_s1_flags;
    logic        [TW-1:0] r_s1_tag;
    logic                 r_s1_valid;

    // Stage 2 (output) registers
    logic signed [OW-1:0] r_res;
    logic        [TW-1:0] r_tag;
    logic                 r_sat;
    logic                 r_valid;

    logic                 w_s2_adv;
    logic                 w_in_xfer;
    logic signed [IW+1:0] w_rnd;
    logic signed [IW+1:0] w_sum;
    logic signed [OW-1:0] w_core_res;
    logic                 w_core_sat;

    // Bubble-collapsing handshake: a stage moves whenever its successor
    // is empty or draining, so ready_o never looks at valid_i
    assign w_s2_adv  = !r_valid || ready_i;
    assign ready_o   = !r_s1_valid || w_s2_adv;
    assign w_in_xfer = valid_i && ready_o;

    // Update rounding constant is folded into the stage-1 neighbour sum
    assign w_rnd = flags_i[FLG_PRED] ? '0 : (IW+2)'(2);
    assign w_sum = (IW+2)'(left_i) + (IW+2)'(right_i) + w_rnd;

    // Stage 1: capture operands on input transfer, empty when drained
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_sam   <= '0;
            r_s1_sum   <= '0;
            r_s1_flags <= '0;
            r_s1_tag   <= '0;
            r_s1_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_sam   <= sam_i;
            r_s1_sum   <= w_sum;
            r_s1_flags <= flags_i;
            r_s1_tag   <= tag_i;
            r_s1_valid <= 1'b1;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    lift_step_core #(
        .IW  (IW),
        .OW  (OW),
        .SAT (SAT)
    ) u_core (
        .i_flags (r_s1_flags),
        .i_sam   (r_s1_sam),
        .i_sum   (r_s1_sum),
        .o_res   (w_core_res),
        .o_sat   (w_core_sat)
    );

    // Stage 2: register the result; hold everything while stalled
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_res   <= '0;
            r_tag   <= '0;
            r_sat   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res <= w_core_res;
                r_tag <= r_s1_tag;
                r_sat <= w_core_sat;
            end
        end
    end

    assign res_o   = r_res;
    assign tag_o   = r_tag;
    assign sat_o   = r_sat;
    assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_lift_step_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lift_step_pipe
// Description : Self-checking bench for lift_step_pipe. Three instances share
//               one stimulus stream: OW=11/SAT=1, OW=9/SAT=1, OW=9/SAT=0.
//               Expected results are queued on input transfer and compared
//               on output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lift_step_pipe;

    logic              clk = 1'b0;
    logic              rst_n;
    logic        [2:0] flags;
    logic signed [9:0] left, sam, right;
    logic        [3:0] tag;
    logic              valid_i, ready_i;

    logic               ready_a, ready_b, ready_c;
    logic signed [10:0] res_a;
    logic signed [8:0]  res_b, res_c;
    logic        [3:0]  tag_a, tag_b, tag_c;
    logic               sat_a, sat_b, sat_c;
    logic               valid_a, valid_b, valid_c;

    always #5 clk = ~clk;

    lift_step_pipe #(.IW(10), .OW(11), .TW(4), .SAT(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .flags_i(flags), .left_i(left), .sam_i(sam),
        .right_i(right), .tag_i(tag), .valid_i(valid_i), .ready_o(ready_a),
        .res_o(res_a), .tag_o(tag_a), .sat_o(sat_a), .valid_o(valid_a), .ready_i(ready_i));
    lift_step_pipe #(.IW(10), .OW(9), .TW(4), .SAT(1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .flags_i(flags), .left_i(left), .sam_i(sam),
        .right_i(right), .tag_i(tag), .valid_i(valid_i), .ready_o(ready_b),
        .res_o(res_b), .tag_o(tag_b), .sat_o(sat_b), .valid_o(valid_b), .ready_i(ready_i));
    lift_step_pipe #(.IW(10), .OW(9), .TW(4), .SAT(0)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .flags_i(flags), .left_i(left), .sam_i(sam),
        .right_i(right), .tag_i(tag), .valid_i(valid_i), .ready_o(ready_c),
        .res_o(res_c), .tag_o(tag_c), .sat_o(sat_c), .valid_o(valid_c), .ready_i(ready_i));

    typedef struct {
        logic [2:0] f;
        int         l, s, r;
        logic [3:0] t;
        bit         has_lit;
        int         lit11, lit9s, lit9w;
        bit         lsat11, lsat9s, lsat9w;
    } stim_t;

    typedef struct {
        int         res11, res9s, res9w;
        bit         sat11, sat9s, sat9w;
        logic [3:0] tag;
        bit         has_lit;
        int         lit11, lit9s, lit9w;
        bit         lsat11, lsat9s, lsat9w;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference lifting arithmetic on plain integers
    function automatic int model_full(logic [2:0] f, int l, int s, int r);
        if (!f[2]) return s;
        case (f[1:0])
            2'b01:   return s - ((l + r) >>> 1);
            2'b00:   return s + ((l + r + 2) >>> 2);
            2'b11:   return s + ((l + r) >>> 1);
            default: return s - ((l + r + 2) >>> 2);
        endcase
    endfunction

    // Reference narrowing: clamp, or modular wrap into the signed range
    function automatic void model_narrow(int v, int ow, bit sat, output int res, output bit flag);
        int hi, lo, m;
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        m  = 1 << ow;
        if (sat) begin
            if (v > hi)      begin res = hi; flag = 1'b1; end
            else if (v < lo) begin res = lo; flag = 1'b1; end
            else             begin res = v;  flag = 1'b0; end
        end else begin
            res = ((v % m) + m) % m;
            if (res > hi) res = res - m;
            flag = (res != v);
        end
    endfunction

    function automatic exp_t make_exp(stim_t s);
        exp_t e;
        int   full;
        full = model_full(s.f, s.l, s.s, s.r);
        model_narrow(full, 11, 1'b1, e.res11, e.sat11);
        model_narrow(full, 9,  1'b1, e.res9s, e.sat9s);
        model_narrow(full, 9,  1'b0, e.res9w, e.sat9w);
        e.tag     = s.t;
        e.has_lit = s.has_lit;
        e.lit11   = s.lit11;  e.lit9s  = s.lit9s;  e.lit9w  = s.lit9w;
        e.lsat11  = s.lsat11; e.lsat9s = s.lsat9s; e.lsat9w = s.lsat9w;
        return e;
    endfunction

    task automatic drive(stim_t s);
        flags = s.f;
        left  = 10'(s.l);
        sam   = 10'(s.s);
        right = 10'(s.r);
        tag   = s.t;
    endtask

    function automatic stim_t rnd_stim(logic [3:0] t);
        stim_t s;
        logic [2:0] fl [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        s.f = fl[$urandom_range(0, 4)];
        s.l = int'($urandom_range(0, 1023)) - 512;
        s.s = int'($urandom_range(0, 1023)) - 512;
        s.r = int'($urandom_range(0, 1023)) - 512;
        s.t = t;
        s.has_lit = 1'b0;
        s.lit11 = 0; s.lit9s = 0; s.lit9w = 0;
        s.lsat11 = 0; s.lsat9s = 0; s.lsat9w = 0;
        return s;
    endfunction

    // Outputs idle and ready_o high while reset is held
    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        flags = '0; left = '0; sam = '0; right = '0; tag = '0;
        #2;
        n_vec++;
        if (valid_a !== 1'b0 || res_a !== 11'sd0 || tag_a !== 4'd0 || sat_a !== 1'b0 || ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: valid=%b res=%0d tag=%0d sat=%b ready=%b, want 0 0 0 0 1",
                     valid_a, res_a, tag_a, sat_a, ready_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // All lifting modes, both narrowing flavours, floor rounding, pass-through
    task automatic test_modes();
        stim_t st[$];
        exp_t  e;
        int    idx = 0, cyc = 0, first_x = -1, first_v = -1;
        st.push_back('{3'd5, 68, 218, 163, 4'd1, 1'b1, 103, 103, 103, 1'b0, 1'b0, 1'b0});
        st.push_back('{3'd4, 68, 218, 163, 4'd2, 1'b1, 276, 255, -236, 1'b0, 1'b1, 1'b1});
        st.push_back('{3'd7, 68, 218, 163, 4'd3, 1'b1, 333, 255, -179, 1'b0, 1'b1, 1'b1});
        st.push_back('{3'd6, 68, 218, 163, 4'd4, 1'b1, 160, 160, 160, 1'b0, 1'b0, 1'b0});
        st.push_back('{3'd5, -3, 0, 0, 4'd5, 1'b1, 2, 2, 2, 1'b0, 1'b0, 1'b0});
        st.push_back('{3'd4, -3, 0, 0, 4'd6, 1'b1, -1, -1, -1, 1'b0, 1'b0, 1'b0});
        st.push_back('{3'd0, 0, -512, 0, 4'd9, 1'b1, -512, -256, 0, 1'b0, 1'b1, 1'b1});
        for (int k = 0; k < 8; k++) st.push_back(rnd_stim(4'(k + 8)));
        ready_i = 1'b1;
        while ((idx < st.size() || sb.size() != 0) && cyc < 300) begin
            @(negedge clk);
            if (idx < st.size()) begin drive(st[idx]); valid_i = 1'b1; end
            else valid_i = 1'b0;
            #1;
            if (valid_a && ready_i) begin
                if (first_v < 0) first_v = cyc;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL modes_stale: valid_o with tag %0d, want no output", tag_a);
                end else begin
                    e = sb.pop_front();
                    if (int'(res_a) !== e.res11 || sat_a !== e.sat11 || tag_a !== e.tag) begin
                        n_err++;
                        $display("FAIL modes_ow11: got res=%0d sat=%b tag=%0d, want res=%0d sat=%b tag=%0d",
                                 res_a, sat_a, tag_a, e.res11, e.sat11, e.tag);
                    end
                    n_vec++;
                    if (int'(res_b) !== e.res9s || sat_b !== e.sat9s || tag_b !== e.tag) begin
                        n_err++;
                        $display("FAIL modes_ow9_sat: got res=%0d sat=%b tag=%0d, want res=%0d sat=%b tag=%0d",
                                 res_b, sat_b, tag_b, e.res9s, e.sat9s, e.tag);
                    end
                    n_vec++;
                    if (int'(res_c) !== e.res9w || sat_c !== e.sat9w || tag_c !== e.tag) begin
                        n_err++;
                        $display("FAIL modes_ow9_wrap: got res=%0d sat=%b tag=%0d, want res=%0d sat=%b tag=%0d",
                                 res_c, sat_c, tag_c, e.res9w, e.sat9w, e.tag);
                    end
                    if (e.has_lit) begin
                        n_vec++;
                        if (int'(res_a) !== e.lit11 || sat_a !== e.lsat11 || int'(res_b) !== e.lit9s ||
                            sat_b !== e.lsat9s || int'(res_c) !== e.lit9w || sat_c !== e.lsat9w) begin
                            n_err++;
                            $display("FAIL modes_table tag %0d: got %0d/%b %0d/%b %0d/%b, want %0d/%b %0d/%b %0d/%b",
                                     e.tag, res_a, sat_a, res_b, sat_b, res_c, sat_c,
                                     e.lit11, e.lsat11, e.lit9s, e.lsat9s, e.lit9w, e.lsat9w);
                        end
                    end
                end
            end
            if (valid_i && ready_a) begin
                if (first_x < 0) first_x = cyc;
                sb.push_back(make_exp(st[idx]));
                idx++;
            end
            cyc++;
        end
        valid_i = 1'b0;
        n_vec++;
        if (idx != st.size() || sb.size() != 0) begin
            n_err++;
            $display("FAIL modes_timeout: sent %0d pending %0d, want sent %0d pending 0", idx, sb.size(), st.size());
        end
        n_vec++;
        if (first_v != first_x + 2) begin
            n_err++;
            $display("FAIL modes_latency: first output %0d cycles after transfer, want 2", first_v - first_x);
        end
    endtask

    // 8 back-to-back samples, downstream stalls on cycles 3..6
    task automatic test_back_to_back();
        stim_t st[$];
        exp_t  e;
        int    idx = 0, cyc = 0, n_out = 0;
        bit    prev_stall = 1'b0, exp_rdy;
        logic signed [10:0] prev_res = '0;
        logic [3:0]         prev_tag = '0;
        logic               prev_sat = 1'b0;
        for (int k = 0; k < 8; k++) st.push_back(rnd_stim(4'(k)));
        while ((idx < 8 || sb.size() != 0) && cyc < 100) begin
            @(negedge clk);
            ready_i = !(cyc >= 3 && cyc <= 6);
            if (idx < 8) begin drive(st[idx]); valid_i = 1'b1; end
            else valid_i = 1'b0;
            #1;
            if (prev_stall) begin
                n_vec++;
                if (res_a !== prev_res || tag_a !== prev_tag || sat_a !== prev_sat || valid_a !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_hold: got res=%0d tag=%0d sat=%b valid=%b, want res=%0d tag=%0d sat=%b valid=1",
                             res_a, tag_a, sat_a, valid_a, prev_res, prev_tag, prev_sat);
                end
            end
            exp_rdy = !(sb.size() == 2 && !ready_i);
            n_vec++;
            if (ready_a !== exp_rdy) begin
                n_err++;
                $display("FAIL bp_ready cycle %0d: got ready_o=%b, want %b", cyc, ready_a, exp_rdy);
            end
            if (valid_a && ready_i) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_stale: valid_o with tag %0d, want no output", tag_a);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    if (int'(res_a) !== e.res11 || sat_a !== e.sat11 || tag_a !== e.tag ||
                        int'(res_c) !== e.res9w || sat_c !== e.sat9w) begin
                        n_err++;
                        $display("FAIL bp_data: got res=%0d sat=%b tag=%0d wrap=%0d/%b, want res=%0d sat=%b tag=%0d wrap=%0d/%b",
                                 res_a, sat_a, tag_a, res_c, sat_c, e.res11, e.sat11, e.tag, e.res9w, e.sat9w);
                    end
                end
            end
            prev_stall = valid_a && !ready_i;
            prev_res = res_a; prev_tag = tag_a; prev_sat = sat_a;
            if (valid_i && ready_a) begin
                sb.push_back(make_exp(st[idx]));
                idx++;
            end
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        n_vec++;
        if (n_out != 8 || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_count: got %0d outputs, %0d pending, want 8 outputs, 0 pending", n_out, sb.size());
        end
    endtask

    // Reset with both stages full, then a fresh sample at latency 2
    task automatic test_reset_midstream();
        exp_t  e;
        stim_t s;
        int    cyc = 0, first_v = -1, n_out = 0;
        ready_i = 1'b0;
        while (sb.size() < 2 && cyc < 20) begin
            @(negedge clk);
            drive(rnd_stim(4'(10 + sb.size())));
            valid_i = 1'b1;
            #1;
            if (valid_i && ready_a) sb.push_back(e);
            cyc++;
        end
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        n_vec++;
        if (valid_a !== 1'b1 || ready_a !== 1'b0) begin
            n_err++;
            $display("FAIL pre_reset_full: got valid_o=%b ready_o=%b, want 1 0", valid_a, ready_a);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (valid_a !== 1'b0 || res_a !== 11'sd0 || tag_a !== 4'd0 || sat_a !== 1'b0 || ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: valid=%b res=%0d tag=%0d sat=%b ready=%b, want 0 0 0 0 1",
                     valid_a, res_a, tag_a, sat_a, ready_a);
        end
        sb.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        s = '{3'd5, 68, 218, 163, 4'd15, 1'b1, 103, 103, 103, 1'b0, 1'b0, 1'b0};
        for (cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin drive(s); valid_i = 1'b1; end
            else valid_i = 1'b0;
            #1;
            if (valid_a && ready_i) begin
                n_vec++;
                n_out++;
                if (first_v < 0) first_v = cyc;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL rst_stale: valid_o with tag %0d res %0d, want no output", tag_a, res_a);
                end else begin
                    e = sb.pop_front();
                    if (int'(res_a) !== e.lit11 || tag_a !== e.tag || sat_a !== e.lsat11) begin
                        n_err++;
                        $display("FAIL rst_first: got res=%0d tag=%0d sat=%b, want res=%0d tag=%0d sat=%b",
                                 res_a, tag_a, sat_a, e.lit11, e.tag, e.lsat11);
                    end
                end
            end
            if (valid_i && ready_a) sb.push_back(make_exp(s));
        end
        n_vec++;
        if (n_out != 1 || first_v != 2) begin
            n_err++;
            $display("FAIL rst_latency: got %0d outputs first at cycle %0d, want 1 output at cycle 2", n_out, first_v);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
